// File: rtl/instr_cache_responder.sv
// Direct-mapped, read-only instruction cache sitting between the fetch stage
// and a slow block-oriented instruction memory. Hits return the addressed
// word combinationally. A miss raises BUSY, fetches the whole 128-bit block,
// installs it, and then lets the original request hit.
module instr_cache_responder #(
    parameter int INDEX_BITS = 3,
    parameter int ADDR_BITS  = 10
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 READ,
    input  logic [31:0]          PC,
    output logic [31:0]          INSTRUCTION,
    output logic                 BUSY,
    output logic                 MEM_READ,
    output logic [ADDR_BITS-5:0] MEM_ADDRESS,
    input  logic [127:0]         MEM_READDATA,
    input  logic                 MEM_BUSY
);

    localparam int TAG_BITS = ADDR_BITS - 4 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEMRD   = 2'd1;
    localparam logic [1:0] UPDATE  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tagStore_q  [LINES];
    logic [127:0]          dataStore_q [LINES];
    logic [ADDR_BITS-5:0]  missAddr_q;
    logic [127:0]          fillBuf_q;
    logic [31:0]           instr_q;

    logic [1:0]            offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] missIndex;
    logic [TAG_BITS-1:0]   missTag;
    logic                  hit;
    logic [31:0]           selWord;
    logic [31:0]           instrOut;
    logic                  unusedPcBits;

    // PC bits above the decoded space and the byte offset within a word are ignored
    assign unusedPcBits = ^{PC[31:ADDR_BITS], PC[1:0]};

    // Split the PC and the captured miss address into their cache fields
    always_comb begin
        offset    = PC[3:2];
        index     = PC[4 +: INDEX_BITS];
        tag       = PC[4 + INDEX_BITS +: TAG_BITS];
        missIndex = missAddr_q[INDEX_BITS-1:0];
        missTag   = missAddr_q[INDEX_BITS +: TAG_BITS];
    end

    // Hit detection and word select; zero-cycle path from PC to INSTRUCTION
    always_comb begin
        hit     = READ & valid_q[index] & (tagStore_q[index] == tag);
        selWord = dataStore_q[index][{offset, 5'b00000} +: 32];
    end

    // Outputs: BUSY stalls on a fresh miss or whenever a fill is in flight
    always_comb begin
        instrOut    = (state_q == IDLE && hit) ? selWord : instr_q;
        INSTRUCTION = instrOut;
        BUSY        = RESET & ((state_q != IDLE) | (READ & ~hit));
        MEM_READ    = (state_q == MEMRD);
        MEM_ADDRESS = missAddr_q;
    end

    // Next-state logic for the miss handler
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (READ && !hit) state_d = MEMRD;
            MEMRD:   if (!MEM_BUSY)    state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state: reset clears valid bits and aborts any fill in progress
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            valid_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instrOut;
            if (state_q == UPDATE) begin
                valid_q[missIndex] <= 1'b1;
            end
        end
    end

    // Datapath storage: miss address, fill buffer and line arrays (not reset)
    always_ff @(posedge CLK) begin
        if (state_q == IDLE && READ && !hit) begin
            missAddr_q <= {tag, index};
        end
        if (state_q == MEMRD && !MEM_BUSY) begin
            fillBuf_q <= MEM_READDATA;
        end
        if (state_q == UPDATE) begin
            tagStore_q[missIndex]  <= missTag;
            dataStore_q[missIndex] <= fillBuf_q;
        end
    end

endmodule

// File: tb/tb_instr_cache_responder.sv
// Self-checking bench for instr_cache_responder: directed scenarios followed
// by random fetches, compared against a simple cache-contents model.
module tb_instr_cache_responder;

   logic          CLK = 1'b0;
   logic          RESET = 1'b0;
   logic          READ = 1'b0;
   logic [31:0]   PC = 32'd0;
   logic [31:0]   INSTRUCTION;
   logic          BUSY;
   logic          MEM_READ;
   logic [5:0]    MEM_ADDRESS;
   logic [127:0]  MEM_READDATA = 128'd0;
   logic          MEM_BUSY = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [127:0]  memBlocks [64];
   bit            modelValid [8];
   logic [2:0]    modelTag [8];
   logic [31:0]   lastInstr;

   instr_cache_responder dut (
      .CLK(CLK),
      .RESET(RESET),
      .READ(READ),
      .PC(PC),
      .INSTRUCTION(INSTRUCTION),
      .BUSY(BUSY),
      .MEM_READ(MEM_READ),
      .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_READDATA(MEM_READDATA),
      .MEM_BUSY(MEM_BUSY)
   );

   // Free-running clock, posedge at 5, 15, 25, ...
   always #5 CLK = ~CLK;

   // Single comparison point
   task automatic checkOutput(input string tagName, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tagName, obs, exp);
      end
   endtask

   // One fetch starting at a negedge; acts as the memory when a miss occurs
   task automatic applyStimulus(input logic [31:0] pc, input int waits);
      logic [5:0]  blk;
      int          idx;
      bit          expHit;
      int          busyCycles;
      int          memCycles;
      logic [31:0] expWord;
      blk     = pc[9:4];
      idx     = int'(pc[6:4]);
      expHit  = modelValid[idx] && (modelTag[idx] == pc[9:7]);
      expWord = memBlocks[blk][32*int'(pc[3:2]) +: 32];
      PC       = pc;
      READ     = 1'b1;
      MEM_BUSY = 1'b1;
      #1;
      if (expHit) begin
         checkOutput("hitBusy", 32'(BUSY), 32'd0);
         checkOutput("hitInstr", INSTRUCTION, expWord);
         checkOutput("hitMemRead", 32'(MEM_READ), 32'd0);
         @(negedge CLK);
      end else begin
         checkOutput("missBusyNow", 32'(BUSY), 32'd1);
         busyCycles = 0;
         memCycles  = 0;
         for (int c = 0; c < 64 && BUSY; c++) begin
            busyCycles++;
            if (MEM_READ) begin
               if (memCycles == 0) checkOutput("memAddr", 32'(MEM_ADDRESS), 32'(blk));
               MEM_READDATA = memBlocks[blk];
               MEM_BUSY     = (memCycles < waits);
               memCycles++;
            end else begin
               MEM_BUSY = 1'b1;
            end
            @(negedge CLK);
            #1;
         end
         MEM_BUSY = 1'b1;
         checkOutput("missLatency", 32'(busyCycles), 32'(waits + 3));
         checkOutput("memReadCycles", 32'(memCycles), 32'(waits + 1));
         checkOutput("fillInstr", INSTRUCTION, expWord);
         checkOutput("memReadDone", 32'(MEM_READ), 32'd0);
         modelValid[idx] = 1'b1;
         modelTag[idx]   = pc[9:7];
         @(negedge CLK);
      end
      lastInstr = expWord;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         memBlocks[i] = {$urandom, $urandom, $urandom, $urandom};
      end
      memBlocks[0] = {32'h44, 32'h33, 32'h22, 32'h11};
      for (int i = 0; i < 8; i++) modelValid[i] = 1'b0;
      lastInstr = 32'd0;

      // Reset state
      #2;
      checkOutput("rstBusy", 32'(BUSY), 32'd0);
      checkOutput("rstMemRead", 32'(MEM_READ), 32'd0);
      checkOutput("rstInstr", INSTRUCTION, 32'd0);
      @(negedge CLK);
      RESET = 1'b1;

      // Cold miss with five memory wait cycles, then spatial hits
      applyStimulus(32'h000, 5);
      applyStimulus(32'h004, 0);
      applyStimulus(32'h008, 0);
      applyStimulus(32'h00C, 0);

      // Conflict miss at index 0 and the refetch of the evicted block
      applyStimulus(32'h080, 2);
      applyStimulus(32'h000, 1);

      // Reset asserted while the fill is waiting on memory
      PC       = 32'h010;
      READ     = 1'b1;
      MEM_BUSY = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      #1;
      checkOutput("preAbortMemRead", 32'(MEM_READ), 32'd1);
      #2;
      RESET = 1'b0;
      #1;
      checkOutput("abortMemRead", 32'(MEM_READ), 32'd0);
      checkOutput("abortBusy", 32'(BUSY), 32'd0);
      checkOutput("abortInstr", INSTRUCTION, 32'd0);
      READ = 1'b0;
      for (int i = 0; i < 8; i++) modelValid[i] = 1'b0;
      lastInstr = 32'd0;
      @(negedge CLK);
      RESET = 1'b1;
      applyStimulus(32'h000, 3);

      // Zero-wait memory
      applyStimulus(32'h0A4, 0);
      applyStimulus(32'h0A8, 0);

      // No activity while READ is low, even at the top of the address space
      PC   = 32'hFFFF_FFFC;
      READ = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         checkOutput("idleBusy", 32'(BUSY), 32'd0);
         checkOutput("idleMemRead", 32'(MEM_READ), 32'd0);
         checkOutput("idleInstr", INSTRUCTION, lastInstr);
         @(negedge CLK);
      end
      applyStimulus(32'h0AC, 0);

      // Random fetches, including aliased upper PC bits
      for (int i = 0; i < 60; i++) begin
         applyStimulus($urandom, int'($urandom_range(0, 4)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
